// File: rtl/unidade_mult_div.sv
// unidade_mult_div: iterative multiply/divide unit (one bit per cycle) holding HI/LO.
// Define MULTDIV_DIV_EN to build the restoring divider and accept op 10/11.
module unidade_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             mt_hi_i,
  input  logic             mt_lo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  // state | meaning
  // IDLE  | accepts start or MTHI/MTLO writes
  // CALC  | one shift-add or restoring-divide step per cycle
  // FIX   | sign correction, HI/LO write, done pulse
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_mag_q;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               start_ok;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

  always_comb begin
    a_abs    = (op_i[0] & op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
    b_abs    = (op_i[0] & op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
    // accumulator holds {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  end

`ifdef MULTDIV_DIV_EN
  logic               is_div_q, dz_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix, a_orig;

  always_comb begin
    start_ok = start_i;
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_mag_q};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    a_orig   = sign_a_q ? -a_mag_q : a_mag_q;
  end

  assign div_zero_o = dz_q;
`else
  always_comb start_ok = start_i & ~op_i[1];

  assign div_zero_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      b_mag_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULTDIV_DIV_EN
      dz_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            sign_a_q <= op_i[0] & op_a_i[WIDTH-1];
            sign_b_q <= op_i[0] & op_b_i[WIDTH-1];
            a_mag_q  <= a_abs;
`ifdef MULTDIV_DIV_EN
            is_div_q <= op_i[1];
            b_mag_q  <= b_abs;
            acc_q    <= op_i[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
`else
            acc_q    <= {{WIDTH{1'b0}}, b_abs};
`endif
          end else begin
            if (mt_hi_i) hi_q <= op_a_i;
            if (mt_lo_i) lo_q <= op_a_i;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 6'd1;
`ifdef MULTDIV_DIV_EN
          acc_q <= is_div_q ? div_next : mul_next;
`else
          acc_q <= mul_next;
`endif
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MULTDIV_DIV_EN
          if (is_div_q) begin
            if (b_mag_q == '0) begin
              hi_q <= a_orig;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else
`endif
          begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_unidade_mult_div.sv
// Bench for unidade_mult_div: cycle-level reference model plus directed literal checks.
module tb_unidade_mult_div;
  localparam int W = 32;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, mt_hi = 1'b0, mt_lo = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          busy_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  unidade_mult_div #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .op_a_i(op_a), .op_b_i(op_b), .mt_hi_i(mt_hi), .mt_lo_i(mt_lo),
    .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, cyc = 0, t0 = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result {divZero, HI, LO} from plain arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a, b);
    longint unsigned ua, ub, up;
    longint sa, sb, sp, q, r;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    case (o)
      2'b00: begin up = ua * ub; return {1'b0, up[63:0]}; end
      2'b01: begin sp = sa * sb; return {1'b0, sp[63:0]}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        up = ua % ub; ua = ua / ub;
        return {1'b0, up[31:0], ua[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic          m_busy = 0, m_done = 0, m_dz = 0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;
  logic [64:0]   m_pend = '0;
  int            m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_rem = 0;
    end else begin
      m_done = 0; m_dz = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
          {m_dz, m_hi, m_lo} = m_pend;
        end
      end else if (start && (DIV_EN || !op[1])) begin
        m_busy = 1; m_rem = W + 1;
        m_pend = model(op, op_a, op_b);
      end else begin
        if (mt_hi) m_hi = op_a;
        if (mt_lo) m_lo = op_a;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    chk("divZero", div_zero_o, m_dz);
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
  end

  task automatic issue(input logic st, input logic [1:0] o, input logic [W-1:0] a, b,
                       input logic mth, mtl);
    @(negedge clk); #1;
    start = st; op = o; op_a = a; op_b = b; mt_hi = mth; mt_lo = mtl;
    t0 = cyc + 1;
    @(negedge clk); #1;
    start = 0; mt_hi = 0; mt_lo = 0;
  endtask

  task automatic wait_done(input string name, input logic [W-1:0] eh, el, input logic edz);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 45) begin
      @(posedge clk); #1;
      n++;
      if (done_o) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, done_o, 1);
    else begin
      chk({name, "_latency"}, cyc - t0, 33);
      chk({name, "_hi"}, hi_o, eh);
      chk({name, "_lo"}, lo_o, el);
      chk({name, "_dz"}, div_zero_o, edz);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    rst_n = 1;

    issue(0, 2'b00, 32'h1234, 0, 1, 0);
    chk("mthi_idle", hi_o, 32'h1234);

    issue(1, 2'b00, 5, 7, 0, 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_hi", hi_o, 0);
    chk("rst_mid_lo", lo_o, 0);
    @(negedge clk); #1 rst_n = 1;
    repeat (40) @(negedge clk);

    issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
    issue(1, 2'b01, 32'hFFFF_FFFD, 7, 0, 0);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    issue(1, 2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
    wait_done("mult_minsq", 32'h4000_0000, 32'h0, 0);

    issue(1, 2'b00, 5, 7, 0, 1);
    chk("start_mtlo_hold", lo_o, 0);
    wait_done("start_mtlo", 0, 35, 0);

    issue(1, 2'b00, 3, 4, 0, 0);
    @(negedge clk); #1;
    mt_hi = 1; mt_lo = 1; op_a = 32'hDEAD;
    @(negedge clk); #1;
    mt_hi = 0; mt_lo = 0;
    chk("mt_busy_hi", hi_o, 0);
    chk("mt_busy_lo", lo_o, 35);
    wait_done("mt_busy", 0, 12, 0);

`ifdef MULTDIV_DIV_EN
    issue(1, 2'b11, 32'hFFFF_FFF9, 2, 0, 0);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    issue(1, 2'b11, 7, 32'hFFFF_FFFE, 0, 0);
    wait_done("div_negb", 32'h1, 32'hFFFF_FFFD, 0);
    issue(1, 2'b10, 100, 0, 0, 0);
    wait_done("divu_zero", 100, 32'hFFFF_FFFF, 1);
    issue(1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    wait_done("div_ovf", 0, 32'h8000_0000, 0);
    issue(1, 2'b10, 100, 7, 0, 0);
    wait_done("divu", 2, 14, 0);
`else
    issue(0, 2'b00, 32'hAAAA, 0, 0, 1);
    chk("mtlo_idle", lo_o, 32'hAAAA);
    issue(1, 2'b10, 100, 7, 0, 0);
    repeat (40) @(negedge clk);
    #1;
    chk("nodiv_busy", busy_o, 0);
    chk("nodiv_hi", hi_o, 0);
    chk("nodiv_lo", lo_o, 32'hAAAA);
    issue(1, 2'b00, 3, 4, 0, 0);
    wait_done("nodiv_multu", 0, 12, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
